// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   IF stage of a 5-stage MIPS pipeline. Owns the fetch PC, keeps at most one
//   instruction-memory request outstanding, buffers returned words in a small
//   circular FIFO and presents {Instruction, Instr_PC_Plus4} to decode.
//   A taken branch/jump from decode (Redirect_Valid + Alt_PC) steers the PC
//   while preserving exactly one branch delay slot instruction.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  output FIFO entries (>= 1)
//
// Ports
//   CLOCK, RESET                      rising-edge clock, synchronous active-low reset
//   Instr_Req_Valid/Addr/Ready        instruction memory request handshake
//   Instr_Resp_Valid/Data             instruction memory response
//   Instr_Valid/Instruction/
//   Instr_PC_Plus4, ID_Ready          FIFO head toward decode, popped on Valid & Ready
//   Redirect_Valid, Alt_PC            taken branch/jump pulse and its target
//   Perf_Fetched/Squashed/Stall       performance counters
//
// Build option
//   FETCH_PERF_COUNTERS_EN  when defined the Perf_* counters are live and
//                           saturating; otherwise they are tied to zero.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic        Instr_Req_Valid,
    output logic [31:0] Instr_Req_Addr,
    input  logic        Instr_Req_Ready,
    input  logic        Instr_Resp_Valid,
    input  logic [31:0] Instr_Resp_Data,
    output logic        Instr_Valid,
    output logic [31:0] Instruction,
    output logic [31:0] Instr_PC_Plus4,
    input  logic        ID_Ready,
    input  logic        Redirect_Valid,
    input  logic [31:0] Alt_PC,
    output logic [31:0] Perf_Fetched,
    output logic [31:0] Perf_Squashed,
    output logic [31:0] Perf_Stall
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    // Circular-buffer pointer advance.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_IDX) begin
            return PTR_ZERO;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Slot n places after p, modulo the buffer depth (n < BUF_DEPTH).
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [CNT_W-1:0] n);
        logic [31:0] sum;
        sum = 32'(p) + 32'(n);
        if (sum >= 32'(BUF_DEPTH)) begin
            sum = sum - 32'(BUF_DEPTH);
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    state_t           state_r, state_s;
    logic [31:0]      pc_r, pc_s;
    logic [31:0]      req_addr_r;
    logic             squash_r, squash_s;
    logic             pending_r, pending_s;
    logic [31:0]      target_r, target_s;
    logic [PTR_W-1:0] head_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      fifo_ins_r [BUF_DEPTH];
    logic [31:0]      fifo_pc4_r [BUF_DEPTH];

    logic             instr_valid_s, pop_s, flush_s, resp_take_s, drop_s, push_s;
    logic             req_valid_s, accept_s;
    logic [CNT_W-1:0] cnt_pp_s, cnt_kept_s;
    logic [PTR_W-1:0] head_pp_s, wr_idx_s;
    logic [31:0]      alt_s;

    // Datapath qualifiers: pop first, then redirect flush, then response push.
    always_comb begin
        instr_valid_s = (count_r != CNT_ZERO);
        pop_s         = instr_valid_s & ID_Ready;
        cnt_pp_s      = count_r - (pop_s ? CNT_ONE : CNT_ZERO);
        head_pp_s     = pop_s ? ptr_inc(head_r) : head_r;
        // A redirect keeps the post-pop head (the delay slot) and flushes the rest.
        flush_s       = Redirect_Valid & (cnt_pp_s != CNT_ZERO);
        cnt_kept_s    = flush_s ? CNT_ONE : cnt_pp_s;
        resp_take_s   = (state_r == ST_WAIT) & Instr_Resp_Valid;
        // A word arriving behind a retained delay slot is younger than it: drop.
        drop_s        = resp_take_s & (squash_r | flush_s);
        push_s        = resp_take_s & ~drop_s;
        wr_idx_s      = ptr_add(head_pp_s, cnt_kept_s);
        // RESET gating keeps the request port quiet while reset is held.
        req_valid_s   = RESET & (state_r == ST_ISSUE) & (cnt_pp_s < DEPTH_C);
        accept_s      = req_valid_s & Instr_Req_Ready;
        alt_s         = Alt_PC & 32'hFFFF_FFFC;
    end

    // FSM next state: one outstanding request, one bubble per fetch.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_ISSUE: begin
                if (accept_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (Instr_Resp_Valid) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_ISSUE;
        endcase
    end

    // PC, pending-redirect and squash bookkeeping.
    always_comb begin
        pc_s      = pc_r;
        pending_s = pending_r;
        target_s  = target_r;
        if (resp_take_s) begin
            squash_s = 1'b0;
        end else begin
            squash_s = squash_r;
        end
        if (Redirect_Valid) begin
            if (flush_s || (state_r == ST_WAIT) || accept_s) begin
                // Delay slot already identified: head, in-flight word or this request.
                pc_s      = alt_s;
                pending_s = 1'b0;
                if (flush_s && (accept_s || ((state_r == ST_WAIT) && !Instr_Resp_Valid))) begin
                    squash_s = 1'b1;
                end else begin
                    squash_s = squash_s;
                end
            end else begin
                // Delay slot not yet requested: remember the target for later.
                pending_s = 1'b1;
                target_s  = alt_s;
            end
        end else if (accept_s) begin
            if (pending_r) begin
                pc_s      = target_r;
                pending_s = 1'b0;
            end else begin
                pc_s = pc_r + 32'd4;
            end
        end else begin
            pc_s = pc_r;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_r    <= ST_ISSUE;
            pc_r       <= RESET_PC & 32'hFFFF_FFFC;
            req_addr_r <= 32'h0;
            squash_r   <= 1'b0;
            pending_r  <= 1'b0;
            target_r   <= 32'h0;
            head_r     <= PTR_ZERO;
            count_r    <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_addr_r <= accept_s ? pc_r : req_addr_r;
            squash_r   <= squash_s;
            pending_r  <= pending_s;
            target_r   <= target_s;
            head_r     <= head_pp_s;
            count_r    <= cnt_kept_s + (push_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // FIFO storage; contents are only observed through a valid head.
    always_ff @(posedge CLOCK) begin
        if (push_s) begin
            fifo_ins_r[wr_idx_s] <= Instr_Resp_Data;
            fifo_pc4_r[wr_idx_s] <= req_addr_r + 32'd4;
        end
    end

    assign Instr_Req_Valid = req_valid_s;
    assign Instr_Req_Addr  = req_valid_s ? pc_r : 32'h0;
    assign Instr_Valid     = instr_valid_s;
    assign Instruction     = instr_valid_s ? fifo_ins_r[head_r] : 32'h0;
    assign Instr_PC_Plus4  = instr_valid_s ? fifo_pc4_r[head_r] : 32'h0;

`ifdef FETCH_PERF_COUNTERS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return s[31:0];
        end
    endfunction

    logic [31:0] perf_fetched_r, perf_squashed_r, perf_stall_r;
    logic [31:0] squash_inc_s;

    // Squash events this cycle: flushed FIFO entries plus a dropped response.
    always_comb begin
        squash_inc_s = (flush_s ? 32'(cnt_pp_s - CNT_ONE) : 32'h0)
                     + (drop_s ? 32'h1 : 32'h0);
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            perf_fetched_r  <= 32'h0;
            perf_squashed_r <= 32'h0;
            perf_stall_r    <= 32'h0;
        end else begin
            perf_fetched_r  <= sat_add(perf_fetched_r, push_s ? 32'h1 : 32'h0);
            perf_squashed_r <= sat_add(perf_squashed_r, squash_inc_s);
            perf_stall_r    <= sat_add(perf_stall_r,
                                       (instr_valid_s & ~ID_Ready) ? 32'h1 : 32'h0);
        end
    end

    assign Perf_Fetched  = perf_fetched_r;
    assign Perf_Squashed = perf_squashed_r;
    assign Perf_Stall    = perf_stall_r;
`else
    assign Perf_Fetched  = 32'h0;
    assign Perf_Squashed = 32'h0;
    assign Perf_Stall    = 32'h0;
`endif

endmodule
